mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: maximum consecutive grant cycles per requester (legal 1..16); SHALL be the block's only parameter.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  16  request lines, bit i = requester i.
REQ-005 done  input  1  current owner releases the shared path this cycle.
REQ-006 data_in  input  16  one data bit per requester.
REQ-007 gnt  output  16  one-hot grant, registered.
REQ-008 sel  output  4  binary index of the granted requester, registered; drives the 16:1 select.
REQ-009 gnt_valid  output  1  high while a grant is held.
REQ-010 data_out  output  1  data_in[sel] while gnt_valid is high, else 0 (combinational from registered sel).

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no owner) and GRANT (owner = sel).
REQ-012 The block SHALL keep a 4-bit pointer last (index of the most recent owner); the search order SHALL be last+1, last+2, ... wrapping modulo 16, so the winner is the first requester set in req in that order.
REQ-013 IDLE: if req != 0 at a rising edge, the block SHALL enter GRANT at that edge with sel = winner, gnt = 1<<winner, gnt_valid = 1 (1-cycle latency from sampled req to grant); if req == 0 it SHALL stay in IDLE.
REQ-014 GRANT: a 4-bit hold counter SHALL be 0 in the first grant cycle and increment by 1 each further cycle in GRANT.
REQ-015 Release condition SHALL be: done == 1, or req[sel] == 0, or hold counter == MAX_HOLD-1.
REQ-016 On release, last SHALL load sel; in the same edge, if any req bit other than req[sel] is set, the block SHALL grant the winner searched from sel+1 (back-to-back, no idle cycle) with the hold counter reset to 0; otherwise it SHALL go to IDLE.
REQ-017 On release with only req[sel] still set (done or timeout), the same requester SHALL be re-granted immediately as a new grant (counter reset to 0).
REQ-018 Without release, sel, gnt, gnt_valid SHALL remain constant; changes to other req bits SHALL NOT preempt the owner.
REQ-019 gnt SHALL always equal 1<<sel when gnt_valid is 1 and SHALL be 16'h0000 when gnt_valid is 0.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 With MAX_HOLD = 1, every grant SHALL last exactly one cycle.

Reset
REQ-022 On rst high, asynchronously: state = IDLE, gnt = 16'h0000, sel = 4'h0, gnt_valid = 0, hold counter = 0, last = 4'hF (requester 0 highest priority after reset); data_out SHALL therefore be 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant in the same cycle without completing the release sequence; first grant after deassertion SHALL follow REQ-013 from the reset pointer.

Structure
REQ-024 A shared package/include SHALL hold the state encodings (IDLE, GRANT), the requester count 16 and the select width 4.
REQ-025 The rotating priority search SHALL be one combinational sub-module, rr_pick (inputs: 16-bit request vector, 4-bit start index; outputs: 4-bit winner, any-flag); it SHALL be instantiated once, with the 16:1 data select kept in the top level.

Verification
REQ-026 Reset, then req = 16'h0001 -> one edge later gnt = 16'h0001, sel = 0, gnt_valid = 1.
REQ-027 req = 16'h8001 held, done pulsed in every grant's first cycle -> owners sequence 0, 15, 0, 15 with no idle cycles.
REQ-028 req = 16'h0030 held, done = 0 -> gnt = 16'h0010 for exactly 8 cycles, then 16'h0020 for 8 cycles, then 16'h0010 again.
REQ-029 Granted to 9, data_in = 16'h0200 -> data_out = 1; data_in = 16'h0000 -> data_out = 0; in IDLE data_out = 0 for any data_in.
REQ-030 Owner 4 deasserts req[4] with req = 0 otherwise -> next edge IDLE, gnt = 0; then req = 16'hFFFF -> grant to 5.
REQ-031 rst pulsed mid-grant of 7 -> gnt = 0 immediately; after release, req = 16'hFFFF -> grant to 0.

Source files
------------

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin arbiter.
package mux16_rr_arbiter_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// Rotating priority search: first set request at or after start_i, wrapping mod 16.
// Purely combinational; any_o flags a non-empty request vector.
module rr_pick
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] start_i,
  output logic [SEL_W-1:0] winner_o,
  output logic             any_o
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit overwrites earlier ones.
  always_comb begin
    winner_o = start_i;
    idx      = start_i;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start_i + SEL_W'(i);
      if (req_i[idx]) winner_o = idx;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// 16-requester round-robin arbiter with bounded hold and a 16:1 data select.
// Grant appears one edge after request; release hands over back-to-back when others wait.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  input  logic [NREQ-1:0]  data_in,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic             data_out
);

  localparam logic [SEL_W-1:0] HOLD_LAST = SEL_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             vld_q;
  logic [SEL_W-1:0] hold_q;
  logic [SEL_W-1:0] last_q;

  logic [SEL_W-1:0] pick_start;
  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             release_now;

  // On release the new search starts after the current owner, which then becomes last.
  assign pick_start  = ((state_q == GRANT) ? sel_q : last_q) + SEL_W'(1);
  assign release_now = done || !req[sel_q] || (hold_q == HOLD_LAST);

  rr_pick u_rr_pick (
    .req_i    (req),
    .start_i  (pick_start),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
      last_q  <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= GRANT;
            sel_q   <= pick_winner;
            gnt_q   <= NREQ'(1) << pick_winner;
            vld_q   <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            last_q <= sel_q;
            hold_q <= '0;
            if (pick_any) begin
              sel_q <= pick_winner;
              gnt_q <= NREQ'(1) << pick_winner;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              vld_q   <= 1'b0;
            end
          end else begin
            hold_q <= hold_q + SEL_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          vld_q   <= 1'b0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = vld_q;
  assign data_out  = vld_q & data_in[sel_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed vector table, hold/reset sequences, random vs. model.
module tb_mux16_rr_arbiter;

  localparam int MAXH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] data_in;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        gnt_valid;
  logic        data_out;

  int checks   = 0;
  int failures = 0;

  int m_owner;
  int m_hold;
  int m_last;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .data_out  (data_out)
  );

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] din;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        vld;
    logic        dout;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 1; k <= 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 15;
  endtask

  task automatic model_edge(input logic [15:0] r, input logic d);
    if (m_owner < 0) begin
      if (r != 16'h0) begin
        m_owner = pick(r, m_last);
        m_hold  = 0;
      end
    end else if (d || !r[m_owner] || m_hold == MAXH - 1) begin
      m_last  = m_owner;
      m_owner = (r != 16'h0) ? pick(r, m_owner) : -1;
      m_hold  = 0;
    end else begin
      m_hold++;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic d, input logic [15:0] dat);
    @(negedge clk);
    req     = r;
    done    = d;
    data_in = dat;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    logic        ev;
    logic        ed;
    ev = (m_owner >= 0);
    eg = 16'h0;
    ed = 1'b0;
    if (ev) begin
      eg = 16'h1 << m_owner;
      ed = data_in[m_owner];
    end
    chk({tag, "_gnt"},  gnt,       eg);
    chk({tag, "_vld"},  gnt_valid, 16'(ev));
    chk({tag, "_dout"}, data_out,  16'(ed));
    if (ev) chk({tag, "_sel"}, sel, 16'(m_owner));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    req     = 16'h0;
    done    = 1'b0;
    data_in = 16'h0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] exp_g;

    tbl[0]  = '{16'h0001, 1'b0, 16'h0000, 16'h0001, 4'd0,  1'b1, 1'b0};
    tbl[1]  = '{16'h0001, 1'b0, 16'h0001, 16'h0001, 4'd0,  1'b1, 1'b1};
    tbl[2]  = '{16'h8001, 1'b1, 16'h0000, 16'h8000, 4'd15, 1'b1, 1'b0};
    tbl[3]  = '{16'h8001, 1'b1, 16'h8000, 16'h0001, 4'd0,  1'b1, 1'b0};
    tbl[4]  = '{16'h8001, 1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b1};
    tbl[5]  = '{16'h8001, 1'b1, 16'h0000, 16'h0001, 4'd0,  1'b1, 1'b0};
    tbl[6]  = '{16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 1'b1, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[8]  = '{16'h0200, 1'b0, 16'h0200, 16'h0200, 4'd9,  1'b1, 1'b1};
    tbl[9]  = '{16'h0200, 1'b0, 16'h0000, 16'h0200, 4'd9,  1'b1, 1'b0};
    tbl[10] = '{16'h0210, 1'b0, 16'hFDFF, 16'h0200, 4'd9,  1'b1, 1'b0};
    tbl[11] = '{16'h0010, 1'b0, 16'h0010, 16'h0010, 4'd4,  1'b1, 1'b1};
    tbl[12] = '{16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[13] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0020, 4'd5,  1'b1, 1'b0};

    rst     = 1'b1;
    req     = 16'h0;
    done    = 1'b0;
    data_in = 16'hFFFF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_gnt",  gnt,       16'h0000);
    chk("reset_sel",  sel,       16'h0000);
    chk("reset_vld",  gnt_valid, 16'h0000);
    chk("reset_dout", data_out,  16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req, tbl[i].done, tbl[i].din);
      chk($sformatf("vec%0d_gnt", i),  gnt,       tbl[i].gnt);
      chk($sformatf("vec%0d_vld", i),  gnt_valid, 16'(tbl[i].vld));
      chk($sformatf("vec%0d_dout", i), data_out,  16'(tbl[i].dout));
      if (tbl[i].vld) chk($sformatf("vec%0d_sel", i), sel, 16'(tbl[i].sel));
    end

    // Two contenders, no done: each holds for exactly MAXH cycles.
    do_reset();
    for (int k = 0; k < 3 * MAXH; k++) begin
      step(16'h0030, 1'b0, 16'h0000);
      exp_g = (((k / MAXH) % 2) == 0) ? 16'h0010 : 16'h0020;
      chk($sformatf("hold%0d_gnt", k), gnt, exp_g);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(16'h0080, 1'b0, 16'h0080);
    chk("pre_rst_gnt",  gnt,      16'h0080);
    chk("pre_rst_sel",  sel,      16'h0007);
    chk("pre_rst_dout", data_out, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt",  gnt,       16'h0000);
    chk("mid_rst_vld",  gnt_valid, 16'h0000);
    chk("mid_rst_dout", data_out,  16'h0000);
    req = 16'h0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(16'hFFFF, 1'b0, 16'h0000);
    chk("post_rst_gnt", gnt, 16'h0001);
    chk("post_rst_sel", sel, 16'h0000);

    // Random traffic against the reference model.
    do_reset();
    r = 16'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 2) == 0) r = 16'($urandom);
        else r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      end
      step(r, ($urandom_range(0, 5) == 0), 16'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
